rt_bm_arbiter: RTL
==================

// Module: rt_bm_arbiter
// PURPOSE
//  Shares the router (Rt) and buffer manager (Bm) between two requesters using
//  per-resource 4-phase handshakes. Two independent arbiters, one per resource.
//  FIFO-full flags gate new grants. Prog[2:0] selects the arbitration policy.
//  Sits between the requester handshake FSMs and the Rt/Bm datapath.
// PARAMETERS
//  HOLD_MAX  15  max cycles a grant may be held in GRANT before forced release
//  CNT_W      4  width of the hold counter; must satisfy 2**CNT_W > HOLD_MAX
// PORTS
//  clock       in   1  single clock, all logic on posedge
//  reset_n     in   1  reset, synchronous, active-low
//  Rdy1Rt      in   1  requester 1 wants Rt (held until released)
//  Rdy2Rt      in   1  requester 2 wants Rt
//  Rdy1Bm      in   1  requester 1 wants Bm
//  Rdy2Bm      in   1  requester 2 wants Bm
//  Done1       in   1  requester 1 finished with every resource it holds
//  Done2       in   1  requester 2 finished with every resource it holds
//  FullI       in   1  input FIFO full: blocks new Rt grants
//  FullO       in   1  output FIFO full: blocks new Bm grants
//  Prog        in   3  [1:0] 00=round-robin 01=fixed req1 10=fixed req2
//                       11=freeze (no new grants); [2]=1 enables the timeout
//  Gnt1Rt      out  1  Rt granted to requester 1 (registered)
//  Gnt2Rt      out  1  Rt granted to requester 2
//  Gnt1Bm      out  1  Bm granted to requester 1
//  Gnt2Bm      out  1  Bm granted to requester 2
//  BusyRt      out  1  Rt arbiter is not in IDLE
//  BusyBm      out  1  Bm arbiter is not in IDLE
//  TmoRt       out  1  one-cycle pulse when an Rt grant is forcibly released
//  TmoBm       out  1  one-cycle pulse when a Bm grant is forcibly released
// BEHAVIOUR
//  - Reset (reset_n=0 at a posedge): all outputs 0; both FSMs in IDLE; both
//    RR pointers point to req1; hold counters 0. Applies mid-grant too.
//  - Per-resource FSM states: IDLE -> GRANT -> RELEASE -> IDLE.
//  - IDLE: at a posedge with a Rdy asserted, the resource not blocked
//    (Rt: FullI=0, Bm: FullO=0) and Prog[1:0]!=11, the FSM picks a winner,
//    sets its Gnt and enters GRANT. Gnt is high the cycle after Rdy is sampled
//    (1-cycle latency). At most one Gnt per resource is high at any time.
//  - Winner when both requesters ask: RR gives the requester named by the
//    pointer; 01 gives req1; 10 gives req2. A single requester always wins
//    in 00/01/10.
//  - GRANT: the hold counter increments each cycle. Done of the owner sampled
//    -> Gnt drops at that edge; enter RELEASE. If Prog[2]=1 and the counter
//    reaches HOLD_MAX without Done -> Gnt drops, Tmo pulses 1 cycle, enter
//    RELEASE. Done and timeout at the same edge: Done wins, no Tmo pulse.
//  - Entering RELEASE: the RR pointer moves to the other requester (in every
//    mode); the hold counter clears.
//  - RELEASE: the FSM waits for the owner's Rdy=0 and Done=0 (4-phase return
//    to zero), then enters IDLE. No grant is issued in that cycle.
//  - Full flags and Prog changes never revoke a live grant; they affect only
//    the next IDLE decision.
//  - One requester may hold Rt and Bm at once; one Done releases both.
//  - Busy = (state != IDLE), registered with the state.
// CONFIGURATION
//  ARB_STATS_EN defined: adds outputs GntCnt1[15:0] and GntCnt2[15:0] that
//  count IDLE->GRANT events per requester (both resources), saturating at
//  16'hFFFF and cleared by reset. ARB_STATS_EN undefined: these ports and
//  counters do not exist; all other behaviour is identical.
// TESTING
//  1 Rdy1Rt=1, Prog=000, FullI=0 -> Gnt1Rt=1 next cycle; Done1=1 -> Gnt1Rt=0
//    next edge; drop Rdy1Rt/Done1 -> BusyRt=0 one cycle later.
//  2 Rdy1Bm=Rdy2Bm=1 held, Prog=000, Done pulsed each grant -> grants
//    alternate 1,2,1,2; with Prog=001 -> req1 always wins.
//  3 Rdy2Rt=1, FullI=1 for 10 cycles -> no grant; FullI=0 -> Gnt2Rt=1 next
//    cycle. Raise FullI during GRANT -> Gnt2Rt stays 1.
//  4 Prog=100, Rdy1Bm=1, no Done -> Gnt1Bm drops after 15 cycles,
//    TmoBm=1 for exactly 1 cycle; Prog=000 -> Gnt held indefinitely.
//  5 reset_n=0 during GRANT on both resources -> all Gnt/Busy=0 at that
//    edge; RR pointer back to req1 (both Rdy high -> req1 wins first).
//  6 ARB_STATS_EN: 3 grants to req1, 2 to req2 -> GntCnt1=3, GntCnt2=2.

Source files
------------

// File: rtl/rt_bm_arbiter.sv
// Purpose: shares the router (Rt) and the buffer manager (Bm) between two
//   requesters. Each resource has its own 4-phase handshake arbiter
//   (IDLE -> GRANT -> RELEASE -> IDLE).
// Latency: a grant appears one cycle after Rdy is sampled. The grant drops
//   at the edge that samples the owner's Done, or at the edge where the
//   optional hold timeout fires.
// Backpressure: FullI blocks new Rt grants and FullO blocks new Bm grants.
//   Prog[1:0]=11 freezes new grants. None of these revoke a live grant.
// Ports:
//   clock, reset_n            single clock; synchronous active-low reset
//   Rdy1Rt/Rdy2Rt             requester Rt requests
//   Rdy1Bm/Rdy2Bm             requester Bm requests
//   Done1/Done2               per-requester release of every resource it holds
//   FullI/FullO               FIFO-full flags gating new Rt/Bm grants
//   Prog[2:0]                 [1:0] policy (RR / fixed1 / fixed2 / freeze),
//                             [2] hold timeout enable
//   Gnt*, Busy*, Tmo*         registered grant, busy and timeout-pulse outputs
//   GntCnt1/GntCnt2           saturating per-requester grant counters, present
//                             only when ARB_STATS_EN is defined

module rt_bm_arb_unit #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rdy1,
  input  logic       rdy2,
  input  logic       done1,
  input  logic       done2,
  input  logic       blk,
  input  logic [2:0] prog,
  output logic       gnt1,
  output logic       gnt2,
  output logic       busy,
  output logic       tmo,
  output logic       win1,
  output logic       win2
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] HOLD_TOP  = CNT_W'(HOLD_MAX);

  state_t           state;
  logic             owner2;  // 0: requester 1 owns, 1: requester 2 owns
  logic             ptr2;    // round-robin pointer, 0 favours requester 1
  logic [CNT_W-1:0] cnt;

  logic can_grant;
  logic pick2;
  logic own_done;
  logic own_rdy;
  logic hold_exp;

  always_comb begin
    can_grant = (state == IDLE) && (rdy1 || rdy2) && !blk && (prog[1:0] != 2'b11);
    // The pick only matters when can_grant is set, so at least one rdy is high.
    case (prog[1:0])
      2'b00:   pick2 = (rdy1 && rdy2) ? ptr2 : rdy2;
      2'b01:   pick2 = !rdy1;
      2'b10:   pick2 = rdy2;
      default: pick2 = 1'b0;
    endcase
    own_done = owner2 ? done2 : done1;
    own_rdy  = owner2 ? rdy2  : rdy1;
    // The counter holds the number of completed GRANT cycles minus one at the
    // deciding edge, so HOLD_LAST gives exactly HOLD_MAX cycles of grant.
    hold_exp = prog[2] && (cnt >= HOLD_LAST);
    win1     = can_grant && !pick2;
    win2     = can_grant && pick2;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state  <= IDLE;
      owner2 <= 1'b0;
      ptr2   <= 1'b0;
      cnt    <= '0;
      gnt1   <= 1'b0;
      gnt2   <= 1'b0;
      busy   <= 1'b0;
      tmo    <= 1'b0;
    end else begin
      tmo <= 1'b0;
      case (state)
        IDLE: begin
          if (can_grant) begin
            state  <= GRANT;
            busy   <= 1'b1;
            owner2 <= pick2;
            gnt1   <= !pick2;
            gnt2   <= pick2;
            cnt    <= '0;
          end
        end
        GRANT: begin
          if (own_done || hold_exp) begin
            state <= RELEASE;
            gnt1  <= 1'b0;
            gnt2  <= 1'b0;
            ptr2  <= !owner2;
            cnt   <= '0;
            tmo   <= !own_done;  // Done at the same edge wins: no pulse
          end else if (cnt < HOLD_TOP) begin
            // Saturate so a late timeout enable cannot see a wrapped count.
            cnt <= cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (!own_rdy && !own_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          gnt1  <= 1'b0;
          gnt2  <= 1'b0;
        end
      endcase
    end
  end

endmodule

module rt_bm_arbiter #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        Rdy1Rt,
  input  logic        Rdy2Rt,
  input  logic        Rdy1Bm,
  input  logic        Rdy2Bm,
  input  logic        Done1,
  input  logic        Done2,
  input  logic        FullI,
  input  logic        FullO,
  input  logic [2:0]  Prog,
  output logic        Gnt1Rt,
  output logic        Gnt2Rt,
  output logic        Gnt1Bm,
  output logic        Gnt2Bm,
  output logic        BusyRt,
  output logic        BusyBm,
  output logic        TmoRt,
  output logic        TmoBm
`ifdef ARB_STATS_EN
  ,
  output logic [15:0] GntCnt1,
  output logic [15:0] GntCnt2
`endif
);

  logic win1_rt, win2_rt, win1_bm, win2_bm;

  rt_bm_arb_unit #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) u_rt (
    .clock   (clock),
    .reset_n (reset_n),
    .rdy1    (Rdy1Rt),
    .rdy2    (Rdy2Rt),
    .done1   (Done1),
    .done2   (Done2),
    .blk     (FullI),
    .prog    (Prog),
    .gnt1    (Gnt1Rt),
    .gnt2    (Gnt2Rt),
    .busy    (BusyRt),
    .tmo     (TmoRt),
    .win1    (win1_rt),
    .win2    (win2_rt)
  );

  rt_bm_arb_unit #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) u_bm (
    .clock   (clock),
    .reset_n (reset_n),
    .rdy1    (Rdy1Bm),
    .rdy2    (Rdy2Bm),
    .done1   (Done1),
    .done2   (Done2),
    .blk     (FullO),
    .prog    (Prog),
    .gnt1    (Gnt1Bm),
    .gnt2    (Gnt2Bm),
    .busy    (BusyBm),
    .tmo     (TmoBm),
    .win1    (win1_bm),
    .win2    (win2_bm)
  );

`ifdef ARB_STATS_EN
  // Both resources may grant the same requester at one edge, so add 0..2.
  logic [16:0] sum1, sum2;

  always_comb begin
    sum1 = {1'b0, GntCnt1} + {15'd0, win1_rt} + {15'd0, win1_bm};
    sum2 = {1'b0, GntCnt2} + {15'd0, win2_rt} + {15'd0, win2_bm};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      GntCnt1 <= '0;
      GntCnt2 <= '0;
    end else begin
      GntCnt1 <= sum1[16] ? 16'hFFFF : sum1[15:0];
      GntCnt2 <= sum2[16] ? 16'hFFFF : sum2[15:0];
    end
  end
`else
  logic unused_win;
  assign unused_win = ^{win1_rt, win2_rt, win1_bm, win2_bm};
`endif

endmodule
